// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge filter between two first-word-fall-through FIFOs.
//
// A raster-order grayscale frame of WIDTH*HEIGHT bytes is read from the
// upstream FIFO. Exactly one gradient byte is written downstream for every
// pixel position. Border centres always produce 0.
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   in_dout    pixel at the head of the upstream FIFO
//   in_empty   upstream FIFO empty
//   in_rd_en   pops the upstream FIFO this cycle
//   out_din    gradient byte to the downstream FIFO (0 when not writing)
//   out_full   downstream FIFO full
//   out_wr_en  writes out_din this cycle
//
// Build option: define SOBEL_THRESHOLD_EN to binarise interior outputs
// (255 when the saturated magnitude >= THRESHOLD, else 0). Without it,
// the saturated magnitude is emitted and THRESHOLD is unused.
module sobel_filter #(
    parameter int unsigned WIDTH     = 720,
    parameter int unsigned HEIGHT    = 540,
    parameter int unsigned THRESHOLD = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_dout,
    input  logic       in_empty,
    output logic       in_rd_en,
    output logic [7:0] out_din,
    input  logic       out_full,
    output logic       out_wr_en
);

    localparam int unsigned SrLen = 2 * WIDTH + 2;
    localparam int unsigned ColW  = $clog2(WIDTH);
    localparam int unsigned RowW  = $clog2(HEIGHT);
    localparam int unsigned CntW  = $clog2(WIDTH + 1);

    localparam logic [ColW-1:0] ColLast  = ColW'(WIDTH - 1);
    localparam logic [ColW-1:0] ColPen   = ColW'(WIDTH - 2);
    localparam logic [RowW-1:0] RowLast  = RowW'(HEIGHT - 1);
    localparam logic [RowW-1:0] RowPen   = RowW'(HEIGHT - 2);
    localparam logic [CntW-1:0] FillLast = CntW'(WIDTH);

    typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [7:0]      sr_q [SrLen];
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            shift_en;
    logic            advance;

    // sr_q[k] holds the pixel consumed k+1 pops ago; in_dout is the bottom-right tap.
    logic signed [10:0] p00, p01, p02, p10, p12, p20, p21, p22;
    logic signed [10:0] gx, gy, ax, ay;
    logic        [11:0] mag;
    logic        [7:0]  sat;
    logic               border;
    logic        [7:0]  pix;

    assign p22 = {3'b000, in_dout};
    assign p21 = {3'b000, sr_q[0]};
    assign p20 = {3'b000, sr_q[1]};
    assign p12 = {3'b000, sr_q[WIDTH-1]};
    assign p10 = {3'b000, sr_q[WIDTH+1]};
    assign p02 = {3'b000, sr_q[2*WIDTH-1]};
    assign p01 = {3'b000, sr_q[2*WIDTH]};
    assign p00 = {3'b000, sr_q[2*WIDTH+1]};

    assign gx  = (p02 + p12 + p12 + p22) - (p00 + p10 + p10 + p20);
    assign gy  = (p20 + p21 + p21 + p22) - (p00 + p01 + p01 + p02);
    assign ax  = gx[10] ? -gx : gx;
    assign ay  = gy[10] ? -gy : gy;
    assign mag = {1'b0, ax} + {1'b0, ay};
    assign sat = (mag > 12'd255) ? 8'hFF : mag[7:0];

    // Window contents wrap across line/frame edges here, so border centres are forced to 0.
    assign border = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);

`ifdef SOBEL_THRESHOLD_EN
    assign pix = border ? 8'h00 : (({24'b0, sat} >= THRESHOLD) ? 8'hFF : 8'h00);
`else
    assign pix = border ? 8'h00 : sat;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = 8'h00;
        shift_en  = 1'b0;
        advance   = 1'b0;
        // Outputs are gated by reset so nothing moves during the reset cycle itself.
        if (!reset) begin
            unique case (state_q)
                StFill: begin
                    if (!in_empty) begin
                        in_rd_en = 1'b1;
                        shift_en = 1'b1;
                        if (cnt_q == FillLast) begin
                            cnt_d   = '0;
                            state_d = StRun;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StRun: begin
                    if (!in_empty && !out_full) begin
                        in_rd_en  = 1'b1;
                        out_wr_en = 1'b1;
                        out_din   = pix;
                        shift_en  = 1'b1;
                        advance   = 1'b1;
                        // Centre (HEIGHT-2, WIDTH-2) is paired with the frame's last pixel.
                        if (row_q == RowPen && col_q == ColPen) begin
                            state_d = StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (!out_full) begin
                        out_wr_en = 1'b1;
                        advance   = 1'b1;
                        if (row_q == RowLast && col_q == ColLast) begin
                            state_d = StFill;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFill;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            for (int unsigned i = 0; i < SrLen; i++) begin
                sr_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (shift_en) begin
                sr_q[0] <= in_dout;
                for (int unsigned i = 1; i < SrLen; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
            if (advance) begin
                if (col_q == ColLast) begin
                    col_q <= '0;
                    row_q <= (row_q == RowLast) ? '0 : row_q + RowW'(1);
                end else begin
                    col_q <= col_q + ColW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter (WIDTH=4, HEIGHT=4). Frames are
// queued by the stimulus; expected output bytes are computed by a plain
// software Sobel model over each frame and checked in write order.
module tb_sobel_filter;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int THR = 128;

    logic       clock;
    logic       reset;
    logic [7:0] in_dout;
    logic       in_empty;
    logic       in_rd_en;
    logic [7:0] out_din;
    logic       out_full;
    logic       out_wr_en;

    sobel_filter #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .THRESHOLD(THR)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .out_din  (out_din),
        .out_full (out_full),
        .out_wr_en(out_wr_en)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] act_q [$];
    logic [7:0] ref_q [$];
    logic [7:0] frame [N];
    int         rd_count = 0;
    int         wr_count = 0;
    int         first_wr_rd = 0;
    int         pops = 0;
    int         mode = 0;
    int         full_left = 0;
    bit         tog = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return int'(frame[r*W+c]);
    endfunction

    // Reference Sobel on the current frame for centre (r, c).
    function automatic int model_at(input int r, input int c);
        int gx, gy, m;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
        return (m >= THR) ? 255 : 0;
`else
        return m;
`endif
    endfunction

    task automatic push_frame(input int n_push);
        for (int i = 0; i < N; i++) exp_q.push_back(8'(model_at(i / W, i % W)));
        for (int i = 0; i < n_push; i++) src_q.push_back(frame[i]);
    endtask

    task automatic fill_cols(input int a, input int b, input int c, input int d);
        int v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < N; i++) frame[i] = 8'(v[i % W]);
    endtask

    // Compare process: protocol rules every cycle, data against the model on every write.
    always @(negedge clock) begin
        if (reset) begin
            check("reset_rd_en", int'(in_rd_en), 0);
            check("reset_wr_en", int'(out_wr_en), 0);
            check("reset_din", int'(out_din), 0);
        end else begin
            if (in_rd_en) begin
                rd_count++;
                check("pop_while_empty", int'(in_empty), 0);
                if (mode == 2 && pops >= W + 1 && pops < N)
                    check("pop_while_full_run", int'(out_full), 0);
            end
            if (!out_wr_en) begin
                check("idle_din_zero", int'(out_din), 0);
            end else begin
                check("write_while_full", int'(out_full), 0);
                if (wr_count == 0) first_wr_rd = rd_count;
                wr_count++;
                act_q.push_back(out_din);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got %0d expected no write", out_din);
                end else begin
                    check("out_din", int'(out_din), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Upstream/downstream FIFO emulation; inputs change 1 time unit after the edge.
    task automatic drive();
        case (mode)
            1: begin
                in_empty = (src_q.size() == 0) || ($urandom_range(0, 2) == 0);
                out_full = ($urandom_range(0, 2) == 0);
            end
            2: begin
                tog      = ~tog;
                in_empty = (src_q.size() == 0) || tog;
                out_full = (pops >= 8) && (full_left > 0);
                if (out_full) full_left--;
            end
            default: begin
                in_empty = (src_q.size() == 0);
                out_full = 1'b0;
            end
        endcase
        in_dout = (src_q.size() != 0) ? src_q[0] : 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic rd;
        in_empty = 1'b1;
        out_full = 1'b0;
        in_dout  = 8'h00;
        forever begin
            @(negedge clock);
            rd = in_rd_en;
            @(posedge clock);
            #1;
            if (rd && src_q.size() != 0) begin
                void'(src_q.pop_front());
                pops++;
            end
            drive();
        end
    end

    task automatic clear_stats();
        act_q.delete();
        rd_count    = 0;
        wr_count    = 0;
        first_wr_rd = 0;
        pops        = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        clear_stats();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            @(posedge clock);
            k++;
        end
        check("drain_done", int'(src_q.size() == 0 && exp_q.size() == 0), 1);
        repeat (4) @(posedge clock);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        do_reset();
        @(negedge clock);
        check("post_reset_rd_en", int'(in_rd_en), 0);
        check("post_reset_wr_en", int'(out_wr_en), 0);
        check("post_reset_din", int'(out_din), 0);

        // Constant frame: all zeros, first write on the 6th pop.
        @(posedge clock);
        #2;
        for (int i = 0; i < N; i++) frame[i] = 8'h80;
        push_frame(N);
        wait_idle(400);
        check("const_count", wr_count, 16);
        check("first_wr_at_pop", first_wr_rd, 6);
        for (int i = 0; i < act_q.size(); i++) check("const_zero", int'(act_q[i]), 0);

        // Vertical edge 0,0,255,255: interior saturates, border zero.
        clear_stats();
        fill_cols(0, 0, 255, 255);
        push_frame(N);
        wait_idle(400);
        check("edge_count", act_q.size(), 16);
        for (int i = 0; i < act_q.size(); i++)
            check("edge_lit", int'(act_q[i]),
                  (i == 5 || i == 6 || i == 9 || i == 10) ? 255 : 0);
        ref_q = act_q;

        // Soft edge 0,0,25,25: magnitude 100 at (1,1).
        clear_stats();
        fill_cols(0, 0, 25, 25);
`ifdef SOBEL_THRESHOLD_EN
        check("model_soft_11", model_at(1, 1), 0);
`else
        check("model_soft_11", model_at(1, 1), 100);
`endif
        push_frame(N);
        wait_idle(400);
`ifdef SOBEL_THRESHOLD_EN
        check("soft_11", int'(act_q[5]), 0);
`else
        check("soft_11", int'(act_q[5]), 100);
`endif

        // Edge frame again under stalls: 10-cycle full hold mid-RUN, empty toggling.
        clear_stats();
        full_left = 10;
        mode      = 2;
        fill_cols(0, 0, 255, 255);
        push_frame(N);
        wait_idle(800);
        mode = 0;
        check("stall_hold_used", full_left, 0);
        check("stall_count", act_q.size(), 16);
        for (int i = 0; i < act_q.size() && i < ref_q.size(); i++)
            check("stall_same_stream", int'(act_q[i]), int'(ref_q[i]));

        // Reset after 9 pixels, then two back-to-back edge frames.
        clear_stats();
        fill_cols(0, 0, 255, 255);
        push_frame(9);
        k = 0;
        while (rd_count < 9 && k < 200) begin
            @(posedge clock);
            k++;
        end
        check("partial_pops", rd_count, 9);
        repeat (3) @(posedge clock);
        #2;
        check("partial_writes", wr_count, 4);
        do_reset();
        push_frame(N);
        push_frame(N);
        wait_idle(800);
        check("two_frame_count", wr_count, 32);
        if (act_q.size() == 32) begin
            check("two_frame_f0_11", int'(act_q[5]), 255);
            check("two_frame_f1_22", int'(act_q[16 + 10]), 255);
            check("two_frame_f1_00", int'(act_q[16]), 0);
        end

        // Random frames with random stalls, back to back.
        clear_stats();
        mode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++)
                frame[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255))
                                        : ($urandom_range(0, 1) != 0 ? 8'hFF : 8'h00);
            push_frame(N);
        end
        wait_idle(5000);
        mode = 0;
        check("random_count", wr_count, 8 * N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
